// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC sin/cos generator.
// Angles are Q4.12 radians; 1.0 = 4096.
package cordic_pkg;

    localparam int CORDIC_K_INV = 2487;
    localparam int PI_Q         = 12868;
    localparam int HALF_PI_Q    = 6434;

    // atan(2^-i) in Q4.12 for micro-rotation i
    localparam int ATAN [0:11] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ITER   = 2'd1,
        ST_OUT    = 2'd2,
        ST_MSTART = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_rot_core.sv
// Iterative rotation-mode CORDIC datapath: one micro-rotation per cycle after i_go.
// Runs at SIZE+2 bits internally; results are truncated to SIZE on the way out.
module cordic_rot_core
    import cordic_pkg::*;
#(
    parameter int STG  = 12,
    parameter int SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_go,
    input  logic signed [SIZE+1:0] i_x0,
    input  logic signed [SIZE+1:0] i_y0,
    input  logic signed [SIZE+1:0] i_z0,
    output logic                   o_busy,
    output logic                   o_rdy,
    output logic signed [SIZE-1:0] o_x,
    output logic signed [SIZE-1:0] o_y
);

    localparam int W  = SIZE + 2;
    localparam int IW = (STG > 1) ? $clog2(STG) : 1;

    logic signed [W-1:0] r_x, r_y, r_z;
    logic        [IW-1:0] r_iter;
    logic                 r_busy;

    logic signed [W-1:0] w_xShift, w_yShift, w_atan;
    logic                w_dNeg, w_last;

    assign w_dNeg   = r_z[W-1];
    assign w_xShift = r_x >>> r_iter;
    assign w_yShift = r_y >>> r_iter;
    assign w_atan   = W'(ATAN[r_iter]);
    assign w_last   = r_busy && (r_iter == IW'(STG - 1));

    // d = +1 when z >= 0, -1 when z < 0; the final rotation drops busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
        end else if (i_go) begin
            r_busy <= 1'b1;
            r_iter <= '0;
            r_x    <= i_x0;
            r_y    <= i_y0;
            r_z    <= i_z0;
        end else if (r_busy) begin
            r_x    <= w_dNeg ? (r_x + w_yShift) : (r_x - w_yShift);
            r_y    <= w_dNeg ? (r_y - w_xShift) : (r_y + w_xShift);
            r_z    <= w_dNeg ? (r_z + w_atan)   : (r_z - w_atan);
            r_iter <= r_iter + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_rdy  = w_last;
    assign o_x    = r_x[SIZE-1:0];
    assign o_y    = r_y[SIZE-1:0];

endmodule

// File: rtl/cordic_sincos_gen.sv
// Computes sin/cos of three angles in turn, writes each into the Q-matrix stage,
// then holds q_start until that stage reports q_done.
module cordic_sincos_gen
    import cordic_pkg::*;
#(
    parameter int STG  = 12,
    parameter int SIZE = 16,
    parameter int INT  = 4,
    parameter int FRAC = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SIZE-1:0] angle,
    output logic                   load,
    output logic [1:0]             addr,
    output logic signed [SIZE-1:0] sin,
    output logic signed [SIZE-1:0] cos,
    output logic                   q_start,
    input  logic                   q_done,
    output logic                   seq_done
);

    localparam int W = SIZE + 2;
    localparam logic signed [W-1:0] L_PI       = W'(PI_Q);
    localparam logic signed [W-1:0] L_NEG_PI   = -W'(PI_Q);
    localparam logic signed [W-1:0] L_HALF     = W'(HALF_PI_Q);
    localparam logic signed [W-1:0] L_NEG_HALF = -W'(HALF_PI_Q);

    if (INT + FRAC != SIZE) begin : g_badFormat
        $error("cordic_sincos_gen: INT + FRAC must equal SIZE");
    end

    state_t                r_state;
    logic [1:0]            r_idx, r_addrHold;
    logic                  r_negate, r_seqDone;
    logic signed [SIZE-1:0] r_sinHold, r_cosHold;

    logic signed [W-1:0]    w_ang, w_clamp, w_fold;
    logic                   w_neg, w_go, w_coreBusy, w_coreRdy;
    logic signed [SIZE-1:0] w_coreX, w_coreY, w_sin, w_cos;

    assign w_ang = W'(angle);

    // Clamp to +/-pi, then fold into +/-pi/2 where CORDIC converges; the
    // half-turn shift is undone later by negating both outputs.
    always_comb begin
        w_clamp = w_ang;
        if (w_ang > L_PI) begin
            w_clamp = L_PI;
        end else if (w_ang < L_NEG_PI) begin
            w_clamp = L_NEG_PI;
        end
        w_fold = w_clamp;
        w_neg  = 1'b0;
        if (w_clamp > L_HALF) begin
            w_fold = w_clamp - L_PI;
            w_neg  = 1'b1;
        end else if (w_clamp < L_NEG_HALF) begin
            w_fold = w_clamp + L_PI;
            w_neg  = 1'b1;
        end
    end

    assign w_go = (r_state == ST_IDLE) && in_valid;

    cordic_rot_core #(
        .STG  (STG),
        .SIZE (SIZE)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_go   (w_go),
        .i_x0   (W'(CORDIC_K_INV)),
        .i_y0   ('0),
        .i_z0   (w_fold),
        .o_busy (w_coreBusy),
        .o_rdy  (w_coreRdy),
        .o_x    (w_coreX),
        .o_y    (w_coreY)
    );

    assign w_cos = r_negate ? -w_coreX : w_coreX;
    assign w_sin = r_negate ? -w_coreY : w_coreY;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_negate   <= 1'b0;
            r_seqDone  <= 1'b0;
            r_addrHold <= 2'd0;
            r_sinHold  <= '0;
            r_cosHold  <= '0;
        end else begin
            r_seqDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_negate <= w_neg;
                        r_state  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (w_coreRdy) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_addrHold <= r_idx;
                    r_sinHold  <= w_sin;
                    r_cosHold  <= w_cos;
                    if (r_idx == 2'd2) begin
                        r_state <= ST_MSTART;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_MSTART: begin
                    if (q_done) begin
                        r_seqDone <= 1'b1;
                        r_idx     <= 2'd0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The write port shows live results only during OUT and holds the last write otherwise
    assign load     = (r_state == ST_OUT);
    assign addr     = load ? r_idx : r_addrHold;
    assign sin      = load ? w_sin : r_sinHold;
    assign cos      = load ? w_cos : r_cosHold;
    assign q_start  = (r_state == ST_MSTART);
    assign seq_done = r_seqDone;
    assign in_ready = (r_state == ST_IDLE) && !w_coreBusy && !rst;

endmodule

// File: tb/tb_cordic_sincos_gen.sv
// Self-checking bench for cordic_sincos_gen: directed angles, the Q-matrix
// handshake, a mid-angle reset and randomized angles against a real-valued sin/cos model.
module tb_cordic_sincos_gen;

    localparam int STG  = 12;
    localparam int SIZE = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [SIZE-1:0] angle;
    logic                   load;
    logic [1:0]             addr;
    logic signed [SIZE-1:0] sin;
    logic signed [SIZE-1:0] cos;
    logic                   q_start;
    logic                   q_done;
    logic                   seq_done;

    int assertCount = 0;
    int failCount   = 0;
    int expIdx      = 0;
    int expSeq      = 0;
    int seqPulses   = 0;

    always #5 clk = ~clk;

    cordic_sincos_gen #(
        .STG  (STG),
        .SIZE (SIZE),
        .INT  (4),
        .FRAC (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .angle    (angle),
        .load     (load),
        .addr     (addr),
        .sin      (sin),
        .cos      (cos),
        .q_start  (q_start),
        .q_done   (q_done),
        .seq_done (seq_done)
    );

    always @(negedge clk) begin
        if (!rst && seq_done) seqPulses++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol = 0);
        assertCount++;
        if (observed > expected + tol || observed < expected - tol) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Reference: clamp to +/-pi in Q4.12 and evaluate sin/cos in real arithmetic
    function automatic void refSinCos(input int theta, output int s, output int c);
        int  t;
        real r;
        t = theta;
        if (t > 12868)  t = 12868;
        if (t < -12868) t = -12868;
        r = real'(t) / 4096.0;
        s = int'($sin(r) * 4096.0);
        c = int'($cos(r) * 4096.0);
    endfunction

    task automatic applyStimulus(input int theta, input int tol, input bit junkValid);
        int n;
        int s, c;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ready_wait", int'(in_ready), 1);
        angle    = SIZE'(theta);
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (junkValid) angle = 16'($urandom);
        else in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) checkOutput("ready_busy", int'(in_ready), 0);
            if (load) break;
        end
        in_valid = 1'b0;
        checkOutput("latency", n + 1, STG + 1);
        if (load) begin
            refSinCos(theta, s, c);
            checkOutput("addr", int'(addr), expIdx);
            checkOutput("sin", int'(sin), s, tol);
            checkOutput("cos", int'(cos), c, tol);
            if (expIdx == 2) begin
                expIdx = 0;
                expSeq++;
            end else begin
                expIdx++;
            end
            @(posedge clk); #1;
            checkOutput("load_pulse", int'(load), 0);
            checkOutput("sin_hold", int'(sin), s, tol);
            checkOutput("cos_hold", int'(cos), c, tol);
        end
    endtask

    initial begin
        int loadCount;
        int theta;
        rst      = 1'b1;
        in_valid = 1'b0;
        q_done   = 1'b0;
        angle    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_load", int'(load), 0);
        checkOutput("rst_addr", int'(addr), 0);
        checkOutput("rst_sin", int'(sin), 0);
        checkOutput("rst_cos", int'(cos), 0);
        checkOutput("rst_q_start", int'(q_start), 0);
        checkOutput("rst_seq_done", int'(seq_done), 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", int'(in_ready), 1);

        $display("[TB] directed angles and Q-matrix handshake");
        applyStimulus(0, 6, 1'b0);
        applyStimulus(6434, 6, 1'b0);
        applyStimulus(9651, 6, 1'b0);
        checkOutput("q_start_rise", int'(q_start), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("q_start_hold", int'(q_start), 1);
            checkOutput("seq_done_low", int'(seq_done), 0);
        end
        q_done = 1'b1;
        @(posedge clk); #1;
        q_done = 1'b0;
        checkOutput("seq_done_pulse", int'(seq_done), 1);
        checkOutput("q_start_fall", int'(q_start), 0);
        checkOutput("ready_after_seq", int'(in_ready), 1);
        @(posedge clk); #1;
        checkOutput("seq_done_once", int'(seq_done), 0);

        applyStimulus(-2145, 6, 1'b0);

        $display("[TB] reset during second angle");
        angle    = 16'sd1000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        expIdx = 0;
        loadCount = 0;
        for (int i = 0; i < 20; i++) begin
            if (load) loadCount++;
            @(posedge clk); #1;
        end
        checkOutput("no_load_after_rst", loadCount, 0);
        applyStimulus(1000, 6, 1'b0);

        $display("[TB] clamp limits and randomized angles");
        q_done = 1'b1;
        applyStimulus(32767, 6, 1'b0);
        applyStimulus(-32768, 6, 1'b0);
        for (int i = 0; i < 24; i++) begin
            theta = int'($urandom_range(28000, 0)) - 14000;
            applyStimulus(theta, 8, 1'(($urandom_range(1, 0))));
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("seq_count", seqPulses, expSeq);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
